// File: rtl/piece_drop_fsm_pkg.sv
// Shared definitions for the piece-drop block.
//   state_t : FSM state encoding (IDLE, CHECK, FALL, COMMIT)
//   row_w() : width of a row index for a board with 'rows' rows (min 1)
//   col_w() : width of a column index for a board with 'cols' columns (min 1)
package piece_drop_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      FALL   = 2'd2,
      COMMIT = 2'd3
   } state_t;

   function automatic int row_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

   function automatic int col_w(input int cols);
      return (cols > 1) ? $clog2(cols) : 1;
   endfunction

endpackage

// File: rtl/piece_drop_fsm_drop_target.sv
// drop_target: combinational landing-row search for one column.
//   board0/board1 : per-player occupancy, indexed [row][col]
//   col           : column to search
//   target        : lowest free cell (highest row index) in that column
//   full          : column has no free cell, or col is out of range
module drop_target
   import piece_drop_fsm_pkg::*;
#(
   parameter int ROWS = 6,
   parameter int COLS = 7
) (
   input  logic [ROWS-1:0][COLS-1:0] board0,
   input  logic [ROWS-1:0][COLS-1:0] board1,
   input  logic [col_w(COLS)-1:0]    col,
   output logic [row_w(ROWS)-1:0]    target,
   output logic                      full
);

   localparam int ROW_W = row_w(ROWS);

   logic [ROWS-1:0] empty;
   logic            col_oob;

   // The column index can encode values past COLS-1 when COLS is not a
   // power of two; such a column is treated like a full one.
   assign col_oob = 32'(col) >= COLS;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign empty[r] = ~(board0[r][col] | board1[r][col]);
   end

   // Scan top to bottom; the last empty row seen is the deepest one.
   always_comb begin
      logic [ROWS-1:0] e;
      logic            any;
      e      = empty;
      any    = 1'b0;
      target = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (e[0]) begin
            target = ROW_W'(r);
            any    = 1'b1;
         end
         e = e >> 1;
      end
      full = col_oob | ~any;
   end

endmodule

// File: rtl/piece_drop_fsm.sv
// piece_drop_fsm: accepts a drop request, finds the landing row once, then
// animates the piece down one row per step_tick and pulses a commit.
//   clk, reset            : clock, async active-high reset
//   board0, board1        : occupancy inputs, sampled only in CHECK
//   req_valid/ready/col/player : drop request handshake
//   step_tick             : animation strobe (only acts in FALL)
//   cancel                : abort an in-flight drop (only acts in FALL)
//   anim_valid/row/col    : falling-piece position
//   commit_valid/row/col/player : one-cycle landing pulse
//   err_full              : one-cycle pulse for a full or out-of-range column
module piece_drop_fsm
   import piece_drop_fsm_pkg::*;
#(
   parameter int ROWS = 6,
   parameter int COLS = 7
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ROWS-1:0][COLS-1:0] board0,
   input  logic [ROWS-1:0][COLS-1:0] board1,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [col_w(COLS)-1:0]    req_col,
   input  logic                      req_player,
   input  logic                      step_tick,
   input  logic                      cancel,
   output logic                      anim_valid,
   output logic [row_w(ROWS)-1:0]    anim_row,
   output logic [col_w(COLS)-1:0]    anim_col,
   output logic                      commit_valid,
   output logic [row_w(ROWS)-1:0]    commit_row,
   output logic [col_w(COLS)-1:0]    commit_col,
   output logic                      commit_player,
   output logic                      err_full
);

   localparam int ROW_W = row_w(ROWS);
   localparam int COL_W = col_w(COLS);

   state_t           state;
   logic [COL_W-1:0] lat_col;
   logic             lat_player;
   logic [ROW_W-1:0] tgt_q;
   logic [ROW_W-1:0] target;
   logic             full;

   drop_target #(.ROWS(ROWS), .COLS(COLS)) u_target (
      .board0 (board0),
      .board1 (board1),
      .col    (lat_col),
      .target (target),
      .full   (full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         lat_col       <= '0;
         lat_player    <= 1'b0;
         tgt_q         <= '0;
         req_ready     <= 1'b1;
         anim_valid    <= 1'b0;
         anim_row      <= '0;
         anim_col      <= '0;
         commit_valid  <= 1'b0;
         commit_row    <= '0;
         commit_col    <= '0;
         commit_player <= 1'b0;
         err_full      <= 1'b0;
      end else begin
         // Pulses and commit fields default low every cycle.
         commit_valid  <= 1'b0;
         commit_row    <= '0;
         commit_col    <= '0;
         commit_player <= 1'b0;
         err_full      <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lat_col    <= req_col;
                  lat_player <= req_player;
                  req_ready  <= 1'b0;
                  state      <= CHECK;
               end
            end
            CHECK: begin
               if (full) begin
                  err_full  <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  // Target is frozen here; later board changes are ignored.
                  tgt_q      <= target;
                  anim_valid <= 1'b1;
                  anim_row   <= '0;
                  anim_col   <= lat_col;
                  state      <= FALL;
               end
            end
            FALL: begin
               // cancel takes priority over any tick in the same cycle
               if (cancel) begin
                  anim_valid <= 1'b0;
                  anim_row   <= '0;
                  anim_col   <= '0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end else if (step_tick) begin
                  if (anim_row == tgt_q) begin
                     anim_valid    <= 1'b0;
                     anim_row      <= '0;
                     anim_col      <= '0;
                     commit_valid  <= 1'b1;
                     commit_row    <= tgt_q;
                     commit_col    <= lat_col;
                     commit_player <= lat_player;
                     state         <= COMMIT;
                  end else begin
                     anim_row <= anim_row + 1'b1;
                  end
               end
            end
            COMMIT: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piece_drop_fsm.sv
// Directed bench for piece_drop_fsm: a vector table of complete drops on a
// 6x7 instance, hand-written cancel/reset/board-change sequences, and a
// short run on a 4x5 instance.
module tb_piece_drop_fsm;

   logic clk;
   logic reset;

   // 6x7 instance
   logic [5:0][6:0] b0a, b1a;
   logic            req_valid_a, req_ready_a, req_player_a;
   logic [2:0]      req_col_a;
   logic            tick_a, cancel_a;
   logic            anim_valid_a, commit_valid_a, commit_player_a, err_full_a;
   logic [2:0]      anim_row_a, anim_col_a, commit_row_a, commit_col_a;

   // 4x5 instance
   logic [3:0][4:0] b0b, b1b;
   logic            req_valid_b, req_ready_b, req_player_b;
   logic [2:0]      req_col_b;
   logic            tick_b, cancel_b;
   logic            anim_valid_b, commit_valid_b, commit_player_b, err_full_b;
   logic [1:0]      anim_row_b, commit_row_b;
   logic [2:0]      anim_col_b, commit_col_b;

   int tests = 0;
   int fails = 0;

   piece_drop_fsm #(.ROWS(6), .COLS(7)) dut_a (
      .clk(clk), .reset(reset), .board0(b0a), .board1(b1a),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_col(req_col_a),
      .req_player(req_player_a), .step_tick(tick_a), .cancel(cancel_a),
      .anim_valid(anim_valid_a), .anim_row(anim_row_a), .anim_col(anim_col_a),
      .commit_valid(commit_valid_a), .commit_row(commit_row_a),
      .commit_col(commit_col_a), .commit_player(commit_player_a),
      .err_full(err_full_a)
   );

   piece_drop_fsm #(.ROWS(4), .COLS(5)) dut_b (
      .clk(clk), .reset(reset), .board0(b0b), .board1(b1b),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_col(req_col_b),
      .req_player(req_player_b), .step_tick(tick_b), .cancel(cancel_b),
      .anim_valid(anim_valid_b), .anim_row(anim_row_b), .anim_col(anim_col_b),
      .commit_valid(commit_valid_b), .commit_row(commit_row_b),
      .commit_col(commit_col_b), .commit_player(commit_player_b),
      .err_full(err_full_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]      col;
      logic            player;
      logic [5:0][6:0] b0;
      logic [5:0][6:0] b1;
      int              period;
      logic            exp_err;
      int              exp_row;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Board with the rows flagged in rm (bit r = row r) set in column c.
   function automatic logic [5:0][6:0] colbits(input int c, input logic [5:0] rm);
      logic [5:0][6:0] b;
      b = '0;
      for (int r = 0; r < 6; r++) begin
         if (rm[0]) b = b | (42'(1) << (r * 7 + c));
         rm = rm >> 1;
      end
      return b;
   endfunction

   // Full drop on the 6x7 instance with one tick every 'period' cycles.
   task automatic run_drop(input vec_t v, input int idx);
      string s;
      s = $sformatf("v%0d", idx);
      b0a = v.b0;
      b1a = v.b1;
      check({s, " ready_idle"}, req_ready_a, 1);
      req_valid_a  = 1'b1;
      req_col_a    = v.col;
      req_player_a = v.player;
      step();
      req_valid_a = 1'b0;
      check({s, " ready_check"}, req_ready_a, 0);
      // tick and cancel in CHECK must be ignored
      tick_a   = 1'b1;
      cancel_a = 1'b1;
      step();
      tick_a   = 1'b0;
      cancel_a = 1'b0;
      if (v.exp_err) begin
         check({s, " err_pulse"}, err_full_a, 1);
         check({s, " err_anim"}, anim_valid_a, 0);
         check({s, " err_ready"}, req_ready_a, 1);
         step();
         check({s, " err_clear"}, err_full_a, 0);
         check({s, " err_anim2"}, anim_valid_a, 0);
         check({s, " err_commit"}, commit_valid_a, 0);
      end else begin
         check({s, " fall_valid"}, anim_valid_a, 1);
         check({s, " fall_row0"}, anim_row_a, 0);
         check({s, " fall_col"}, anim_col_a, v.col);
         check({s, " fall_err"}, err_full_a, 0);
         for (int k = 0; k <= v.exp_row; k++) begin
            repeat (v.period - 1) step();
            check($sformatf("%s hold%0d", s, k), anim_row_a, k);
            tick_a = 1'b1;
            step();
            tick_a = 1'b0;
            if (k < v.exp_row) begin
               check($sformatf("%s row%0d", s, k + 1), anim_row_a, k + 1);
               check($sformatf("%s nocommit%0d", s, k), commit_valid_a, 0);
            end else begin
               check({s, " commit"}, commit_valid_a, 1);
               check({s, " commit_row"}, commit_row_a, v.exp_row);
               check({s, " commit_col"}, commit_col_a, v.col);
               check({s, " commit_player"}, commit_player_a, v.player);
               check({s, " commit_anim"}, anim_valid_a, 0);
               check({s, " commit_ready"}, req_ready_a, 0);
            end
         end
         step();
         check({s, " post_commit"}, commit_valid_a, 0);
         check({s, " post_ready"}, req_ready_a, 1);
         check({s, " post_anim_row"}, anim_row_a, 0);
      end
   endtask

   // Accept col on the 6x7 instance and step into FALL.
   task automatic start_a(input logic [2:0] col, input logic player);
      req_valid_a  = 1'b1;
      req_col_a    = col;
      req_player_a = player;
      step();
      req_valid_a = 1'b0;
      step();
   endtask

   task automatic tick_once_a();
      tick_a = 1'b1;
      step();
      tick_a = 1'b0;
   endtask

   initial begin
      logic [5:0][6:0] fullcols;
      logic            seen;

      reset = 1'b1;
      b0a = '0; b1a = '0; req_valid_a = 0; req_col_a = '0; req_player_a = 0;
      tick_a = 0; cancel_a = 0;
      b0b = '0; b1b = '0; req_valid_b = 0; req_col_b = '0; req_player_b = 0;
      tick_b = 0; cancel_b = 0;
      step();
      step();
      check("rst_ready", req_ready_a, 1);
      check("rst_anim", {anim_valid_a, anim_row_a, anim_col_a}, 0);
      check("rst_commit", {commit_valid_a, commit_row_a, commit_col_a, commit_player_a}, 0);
      check("rst_err", err_full_a, 0);
      reset = 1'b0;
      step();

      fullcols = '0;
      for (int c = 0; c < 6; c++) fullcols = fullcols | colbits(c, 6'b111111);

      vecs[0] = '{col:3'd3, player:1'b1, b0:'0, b1:'0, period:4, exp_err:1'b0, exp_row:5};
      vecs[1] = '{col:3'd2, player:1'b0, b0:colbits(2, 6'b101010), b1:colbits(2, 6'b010100),
                  period:1, exp_err:1'b0, exp_row:0};
      vecs[2] = '{col:3'd4, player:1'b1, b0:colbits(4, 6'b010101), b1:colbits(4, 6'b101010),
                  period:1, exp_err:1'b1, exp_row:0};
      vecs[3] = '{col:3'd7, player:1'b0, b0:'0, b1:'0, period:1, exp_err:1'b1, exp_row:0};
      vecs[4] = '{col:3'd0, player:1'b0, b0:'0, b1:colbits(0, 6'b100000),
                  period:2, exp_err:1'b0, exp_row:4};
      vecs[5] = '{col:3'd6, player:1'b1, b0:fullcols | colbits(6, 6'b110000), b1:'0,
                  period:3, exp_err:1'b0, exp_row:3};

      for (int i = 0; i < 6; i++) run_drop(vecs[i], i);
      b0a = '0; b1a = '0;

      // cancel once the piece reaches row 2
      start_a(3'd1, 1'b0);
      tick_once_a();
      tick_once_a();
      check("cx_row2", anim_row_a, 2);
      cancel_a = 1'b1;
      step();
      cancel_a = 1'b0;
      check("cx_anim", anim_valid_a, 0);
      check("cx_row", anim_row_a, 0);
      check("cx_ready", req_ready_a, 1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick_a = 1'b1;
         step();
         seen = seen | commit_valid_a;
      end
      tick_a = 1'b0;
      check("cx_no_commit", seen, 0);

      // cancel coincident with the final tick (target row 0)
      b0a = colbits(2, 6'b101010);
      b1a = colbits(2, 6'b010100);
      start_a(3'd2, 1'b1);
      check("cf_fall", anim_valid_a, 1);
      tick_a   = 1'b1;
      cancel_a = 1'b1;
      step();
      tick_a   = 1'b0;
      cancel_a = 1'b0;
      check("cf_no_commit", commit_valid_a, 0);
      check("cf_anim", anim_valid_a, 0);
      check("cf_ready", req_ready_a, 1);
      step();
      check("cf_no_commit2", commit_valid_a, 0);
      b0a = '0; b1a = '0;

      // landing column fills during FALL: target stays row 5
      start_a(3'd5, 1'b0);
      tick_once_a();
      b0a = colbits(5, 6'b110000);
      b1a = colbits(5, 6'b001000);
      for (int k = 1; k < 6; k++) tick_once_a();
      check("bc_commit", commit_valid_a, 1);
      check("bc_row", commit_row_a, 5);
      check("bc_col", commit_col_a, 5);
      step();
      b0a = '0; b1a = '0;

      // async reset with the piece at row 3
      start_a(3'd0, 1'b1);
      for (int k = 0; k < 3; k++) tick_once_a();
      check("rs_row3", anim_row_a, 3);
      reset = 1'b1;
      #1;
      check("rs_anim", {anim_valid_a, anim_row_a, anim_col_a}, 0);
      check("rs_commit", {commit_valid_a, commit_row_a, commit_col_a, commit_player_a}, 0);
      check("rs_err", err_full_a, 0);
      check("rs_ready", req_ready_a, 1);
      step();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick_a = 1'b1;
         step();
         seen = seen | commit_valid_a | anim_valid_a;
      end
      tick_a = 1'b0;
      check("rs_no_commit", seen, 0);
      check("rs_ready2", req_ready_a, 1);

      // 4x5 instance, empty board, column 4 lands on row 3 after 4 ticks
      req_valid_b  = 1'b1;
      req_col_b    = 3'd4;
      req_player_b = 1'b1;
      step();
      req_valid_b = 1'b0;
      step();
      check("b_fall", anim_valid_b, 1);
      for (int k = 0; k < 3; k++) begin
         tick_b = 1'b1;
         step();
         tick_b = 1'b0;
         check($sformatf("b_row%0d", k + 1), anim_row_b, k + 1);
      end
      tick_b = 1'b1;
      step();
      tick_b = 1'b0;
      check("b_commit", commit_valid_b, 1);
      check("b_commit_row", commit_row_b, 3);
      check("b_commit_col", commit_col_b, 4);
      step();
      check("b_ready", req_ready_b, 1);

      // 4x5 instance, column 5 is out of range
      req_valid_b = 1'b1;
      req_col_b   = 3'd5;
      step();
      req_valid_b = 1'b0;
      step();
      check("b_oob_err", err_full_b, 1);
      check("b_oob_anim", anim_valid_b, 0);
      step();
      check("b_oob_clear", err_full_b, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/piece_drop_fsm.md
PIECE_DROP_FSM -- requirements
Module: piece_drop_fsm

Interface
REQ-001 Parameter: ROWS, 6, board rows; row ROWS-1 is the bottom row, row 0 the top; legal range 2..16.
REQ-002 Parameter: COLS, 7, board columns; legal range 2..16.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: board0  input  [ROWS-1:0][COLS-1:0]  player-0 occupancy, indexed [row][col].
REQ-006 Port: board1  input  [ROWS-1:0][COLS-1:0]  player-1 occupancy, same indexing.
REQ-007 Port: req_valid  input  1  a drop request is presented.
REQ-008 Port: req_ready  output  1  the block accepts a request this cycle.
REQ-009 Port: req_col  input  COL_W  target column, where COL_W = max(1, clog2(COLS)).
REQ-010 Port: req_player  input  1  player making the move (0 or 1).
REQ-011 Port: step_tick  input  1  animation step strobe, one cycle wide.
REQ-012 Port: cancel  input  1  abort an in-flight drop.
REQ-013 Port: anim_valid  output  1  a falling piece is being shown.
REQ-014 Port: anim_row  output  ROW_W  current row of the falling piece, where ROW_W = max(1, clog2(ROWS)).
REQ-015 Port: anim_col  output  COL_W  column of the falling piece.
REQ-016 Port: commit_valid  output  1  one-cycle pulse: the piece has landed.
REQ-017 Port: commit_row, commit_col, commit_player  output  ROW_W/COL_W/1  landing cell and owner; valid only while commit_valid=1.
REQ-018 Port: err_full  output  1  one-cycle pulse: request rejected because the column is full or out of range.

Function
REQ-019 States SHALL be IDLE, CHECK, FALL and COMMIT; the block SHALL drive req_ready=1 only in IDLE.
REQ-020 Acceptance SHALL occur when req_valid=1 and req_ready=1; the block SHALL then latch req_col and req_player and go to CHECK.
REQ-021 In CHECK, the landing target SHALL be the highest-index row r where (board0|board1)[r][col]=0; the board SHALL be sampled in this cycle only.
REQ-022 If no empty row exists in the column, or col>=COLS, the block SHALL pulse err_full for one cycle and return to IDLE.
REQ-023 Otherwise, on CHECK->FALL the block SHALL set anim_row=0 and anim_valid=1.
REQ-024 In FALL, on step_tick with anim_row==target the block SHALL go to COMMIT; on step_tick otherwise it SHALL increment anim_row by 1; with no tick it SHALL hold.
REQ-025 COMMIT SHALL last exactly one cycle with commit_valid=1, anim_valid=0 and the latched row, col and player, then return to IDLE.
REQ-026 Latency from acceptance to commit_valid SHALL be 2 cycles + (target+1) step_ticks.
REQ-027 cancel in FALL SHALL return the block to IDLE with no commit; cancel SHALL win over a simultaneous final step_tick; cancel SHALL be ignored in other states.
REQ-028 Board changes after CHECK SHALL NOT affect the target; a step_tick in IDLE, CHECK or COMMIT SHALL have no effect.
REQ-029 Outside FALL, anim_valid SHALL be 0 and anim_row SHALL be 0; outside their pulse cycle, commit_valid and err_full SHALL be 0.

Reset
REQ-030 Reset SHALL force IDLE, and reset every output except req_ready to 0; req_ready SHALL be 1 after reset.
REQ-031 Reset mid-FALL or mid-COMMIT SHALL discard the drop; no commit_valid pulse SHALL follow.

Structure
REQ-032 A shared package SHALL hold the state enum and the ROW_W/COL_W width helper functions.
REQ-033 The target search SHALL be a parametrised combinational sub-module, drop_target (inputs board0, board1, col; outputs target and full), instantiated once.

Verification
REQ-034 Empty 6x7 board, req col 3, player 1, tick every 4 cycles -> anim_row steps 0..5, then commit_valid with row 5, col 3, player 1 after 6 ticks.
REQ-035 Column 2 with rows 5..1 occupied (mixed owners), req col 2 -> anim_row=0 on the first tick leads to commit with row 0.
REQ-036 Column 4 full, and separately req col 7 -> single err_full pulse each, no anim_valid, req_ready=1 again 2 cycles after acceptance.
REQ-037 cancel asserted with anim_row=2 and coincident with the final tick on another drop -> no commit_valid in either case, and the block returns to IDLE.
REQ-038 Assert reset with anim_row=3 -> all outputs 0 immediately and req_ready=1; no commit afterwards; board bits set in the landing column during FALL do not change commit_row.
REQ-039 ROWS=4, COLS=5 instance, empty board, req col 4 -> commit with row 3 after 4 ticks.
